// File: rtl/nanov_mul_seq.sv
// Sequencer for the bit-serial nanoV_mul: clears it, feeds one multiplier bit per cycle, shifts out the 32-bit product.
// Latency 35..66 cycles from acceptance (n MUL cycles + 32 READ); result is held in DONE until out_ready.
module nanov_mul_seq (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        mul_rstn,
   output logic [31:0] mul_a,
   output logic        mul_b,
   output logic        mul_read_out,
   input  logic        mul_d
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_MUL   = 3'd2,
      S_READ  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_sh_q, a_sh_d;
   logic [31:0] b_sh_q, b_sh_d;
   logic [31:0] res_sh_q, res_sh_d;
   logic [4:0]  cnt_q, cnt_d;

   logic        accept;
   logic        b_last;

   assign accept = (state_q == S_IDLE) && in_valid;
   // Stop feeding once only bit 0 is left: upper zero bits contribute nothing.
   assign b_last = (b_sh_q[31:1] == 31'd0);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid)          state_d = S_CLEAR;
         S_CLEAR:                        state_d = S_MUL;
         S_MUL:   if (b_last)            state_d = S_READ;
         S_READ:  if (cnt_q == 5'd31)    state_d = S_DONE;
         S_DONE:  if (out_ready)         state_d = S_IDLE;
         default:                        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready     = (state_q == S_IDLE);
      out_valid    = (state_q == S_DONE);
      result       = (state_q == S_DONE) ? res_sh_q : 32'd0;
      mul_a        = (state_q == S_MUL) ? a_sh_q : 32'd0;
      mul_b        = (state_q == S_MUL) ? b_sh_q[0] : 1'b0;
      mul_read_out = (state_q == S_READ);
      mul_rstn     = rstn && (state_q != S_CLEAR);
   end

   always_comb begin
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_sh_d   = op_a;
               b_sh_d   = op_b;
               res_sh_d = 32'd0;
            end
         end
         S_MUL: begin
            a_sh_d = {a_sh_q[30:0], 1'b0};
            b_sh_d = {1'b0, b_sh_q[31:1]};
            if (b_last) begin
               cnt_d = 5'd0;
            end
         end
         S_READ: begin
            // Accumulator emits LSB first, so shift in from the top.
            res_sh_d = {mul_d, res_sh_q[31:1]};
            cnt_d    = cnt_q + 5'd1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         a_sh_q   <= 32'd0;
         b_sh_q   <= 32'd0;
         res_sh_q <= 32'd0;
         cnt_q    <= 5'd0;
      end else begin
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_nanov_mul_seq.sv
// Directed bench for nanov_mul_seq with a behavioural bit-serial multiplier attached.
module tb_nanov_mul_seq;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        mul_rstn;
   logic [31:0] mul_a;
   logic        mul_b;
   logic        mul_read_out;
   logic        mul_d;

   int n_chk  = 0;
   int n_pass = 0;

   nanov_mul_seq dut (
      .clk          (clk),
      .rstn         (rstn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .op_a         (op_a),
      .op_b         (op_b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .mul_rstn     (mul_rstn),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_read_out (mul_read_out),
      .mul_d        (mul_d)
   );

   always #5 clk = ~clk;

   // Multiplier model: accumulate a when b, shift right on read_out, d = acc[0].
   logic [31:0] acc;
   always @(posedge clk) begin
      if (!mul_rstn)         acc <= 32'd0;
      else if (mul_read_out) acc <= {1'b0, acc[31:1]};
      else if (mul_b)        acc <= acc + mul_a;
   end
   assign mul_d = acc[0];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat,
                         input int hold, input bit junk);
      int          cyc;
      int          rd_cyc;
      int          clr_cyc;
      int          rdy_busy;
      int          b_ones;
      int          unstable;
      logic [31:0] bseq;
      logic [31:0] held;
      check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      tick();
      in_valid = 1'b0;
      op_a     = 32'h0;
      op_b     = 32'h0;
      cyc = 1; rd_cyc = 0; clr_cyc = 0; rdy_busy = 0; b_ones = 0; bseq = 32'd0;
      while (!out_valid && cyc < 120) begin
         if (!mul_rstn) clr_cyc++;
         if (mul_read_out) rd_cyc++;
         if (in_ready) rdy_busy++;
         if (mul_b) begin
            b_ones++;
            if (cyc >= 2 && cyc <= 33) bseq[cyc-2] = 1'b1;
         end
         if (junk && cyc >= 2) begin
            in_valid = cyc[0];
            op_a     = 32'hdead0000 | 32'(cyc);
            op_b     = 32'h7;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, " result"}, result, exp_res);
      check({tag, " mul_b seq"}, bseq, b);
      check({tag, " mul_b ones"}, 32'(b_ones), 32'($countones(b)));
      check({tag, " read cycles"}, 32'(rd_cyc), 32'd32);
      check({tag, " clear cycles"}, 32'(clr_cyc), 32'd1);
      check({tag, " in_ready busy"}, 32'(rdy_busy), 32'd0);
      held = result;
      unstable = 0;
      for (int h = 0; h < hold; h++) begin
         tick();
         if (!out_valid || result !== held || in_ready) unstable++;
      end
      if (hold > 0) check({tag, " backpressure"}, 32'(unstable), 32'd0);
      check({tag, " in_ready at handshake"}, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " out_valid after"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      rstn      = 1'b0;
      in_valid  = 1'b0;
      op_a      = 32'h0;
      op_b      = 32'h0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst result", result, 32'd0);
      check("rst mul_a", mul_a, 32'd0);
      check("rst mul_b", 32'(mul_b), 32'd0);
      check("rst mul_read_out", 32'(mul_read_out), 32'd0);
      check("rst mul_rstn", 32'(mul_rstn), 32'd0);
      rstn = 1'b1;
      tick();
      check("post-rst mul_rstn", 32'(mul_rstn), 32'd1);

      run_op("3x5", 32'd3, 32'd5, 32'd15, 37, 0, 1'b0);
      run_op("ffxff", 32'hffffffff, 32'hffffffff, 32'h00000001, 66, 0, 1'b0);
      run_op("ax0", 32'h12345678, 32'h0, 32'h0, 35, 0, 1'b0);
      run_op("ovf", 32'h00010000, 32'h00010000, 32'h0, 51, 0, 1'b0);
      run_op("7x6", 32'd7, 32'd6, 32'd42, 37, 0, 1'b0);
      run_op("bp", 32'h1000, 32'h10, 32'h10000, 39, 10, 1'b1);

      // Abort 9x9 part-way through READ.
      in_valid = 1'b1;
      op_a     = 32'd9;
      op_b     = 32'd9;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (!mul_read_out && cyc < 100) begin
         tick();
         cyc++;
      end
      check("abort reached READ", 32'(mul_read_out), 32'd1);
      tick();
      tick();
      tick();
      rstn = 1'b0;
      tick();
      check("abort in_ready", 32'(in_ready), 32'd1);
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort result", result, 32'd0);
      check("abort mul_read_out", 32'(mul_read_out), 32'd0);
      check("abort mul_a", mul_a, 32'd0);
      check("abort mul_b", 32'(mul_b), 32'd0);
      check("abort mul_rstn", 32'(mul_rstn), 32'd0);
      rstn = 1'b1;
      tick();
      run_op("2x21", 32'd2, 32'd21, 32'd42, 39, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/nanov_mul_seq.md
# nanov_mul_seq

Sequencer that drives the bit-serial multiplier (`nanoV_mul`) to compute a 32x32->32 low-word product. It accepts two 32-bit operands over a valid/ready handshake and clears the multiplier's accumulator. It then feeds the shifted multiplicand and one multiplier bit per cycle, shifts the product out over 32 read cycles, and presents the 32-bit result over a valid/ready handshake. It sits between the core's execute stage and the multiplier.

## Interface
- No parameters; operand and result widths are fixed at 32.
- clk  input  1  clock
- rstn  input  1  reset; synchronous, active-low
- in_valid  input  1  operands valid
- in_ready  output  1  sequencer idle, can accept operands
- op_a  input  32  multiplicand
- op_b  input  32  multiplier
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  32  low 32 bits of op_a*op_b
- mul_rstn  output  1  to multiplier rstn; accumulator clear
- mul_a  output  32  to multiplier a
- mul_b  output  1  to multiplier b
- mul_read_out  output  1  to multiplier read_out
- mul_d  input  1  from multiplier d (accumulator bit 0)

## Operation
- States: IDLE, CLEAR, MUL, READ, DONE.
- Internal registers:
  - a_sh, 32 bits
  - b_sh, 32 bits
  - cnt, 5 bits
  - res_sh, 32 bits
- IDLE:
  - in_ready=1.
  - On in_valid: a_sh<=op_a, b_sh<=op_b, go to CLEAR.
- CLEAR:
  - One cycle; mul_rstn=0.
  - Next state is MUL.
- MUL:
  - mul_a=a_sh, mul_b=b_sh[0], mul_read_out=0.
  - Each cycle: a_sh<=a_sh<<1 (zero fill), b_sh<=b_sh>>1.
  - Go to READ when b_sh[31:1]==0; cnt<=0.
  - Cycles spent n = max(1, msb_index(op_b)+1); n=1 for op_b==0.
- READ:
  - mul_read_out=1, mul_b=0.
  - Each cycle: res_sh<={mul_d, res_sh[31:1]}, cnt<=cnt+1.
  - Go to DONE when cnt==31, after 32 cycles.
- DONE:
  - out_valid=1, result=res_sh, held stable.
  - On out_ready, go to IDLE.
- mul_rstn = rstn & (state!=CLEAR).
- mul_a=0 and mul_b=0 outside MUL; mul_read_out=0 outside READ.
- Arithmetic is modulo 2^32; bits shifted out of a_sh are discarded.
- Signedness does not affect the low word; no sign handling.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, result=0.
  - mul_a=0, mul_b=0, mul_read_out=0.
  - mul_rstn=0 while rstn=0.
  - a_sh, b_sh, res_sh, cnt = 0.
- Take the acceptance cycle (in_valid&in_ready) as cycle 0. Then:
  - CLEAR is cycle 1.
  - MUL is cycles 2..n+1.
  - READ is cycles n+2..n+33.
  - out_valid first high in cycle n+34.
- Latency is 35 cycles minimum (op_b<=1) and 66 maximum (op_b[31]=1).
- in_ready=0 from cycle 1 until the cycle after the out handshake.
- No overlap: a new operand pair cannot be accepted in the same cycle as the result handshake.
- out_valid stays high and result stays stable under backpressure indefinitely.
- in_valid while busy is ignored. op_a and op_b are only sampled at acceptance.
- Reset mid-operation (any state):
  - Next cycle state=IDLE with all outputs at reset values.
  - The multiplier is cleared via mul_rstn.
  - No partial result appears.
- out_ready without out_valid has no effect.

## Test plan
- op_a=3, op_b=5 -> n=3, out_valid at cycle 37, result=15; mul_b sequence in MUL is 1,0,1.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> n=32, out_valid at cycle 66, result=0x00000001.
- op_a=0x12345678, op_b=0 -> n=1, out_valid at cycle 35, result=0; mul_b=0 throughout.
- op_a=0x00010000, op_b=0x00010000 -> n=17, result=0 (overflow discarded). Then op_a=7, op_b=6 accepted one cycle after the out handshake -> result=42, with CLEAR asserting mul_rstn=0 for exactly one cycle.
- Hold out_ready=0 for 10 cycles after out_valid with op_a=0x1000, op_b=0x10 -> result stays 0x10000, in_ready stays 0. Also toggle in_valid with other operands while busy -> ignored.
- Assert rstn=0 during READ of op_a=9, op_b=9 -> IDLE and reset outputs next cycle. Then op_a=2, op_b=21 -> result=42 with no residue from the aborted operation.
